// File: rtl/bsg_credit_dispatch_pkg.sv
// Shared constants, helpers and types for the credit-based 1-to-n dispatcher.
package bsg_credit_dispatch_pkg;

    localparam int credit_word_width_lp = 32;

    typedef logic [credit_word_width_lp-1:0] credit_word_t;

    // Index width for n channels; a single bit is the floor even for n <= 2.
    function automatic int lg_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic credit_word_t max_credit(input int w);
        return credit_word_t'((64'(1) << w) - 64'(1));
    endfunction

endpackage

// File: rtl/bsg_credit_dispatch_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, cyclically.
module bsg_credit_dispatch_rr_pick
    import bsg_credit_dispatch_pkg::*;
#(
    parameter int num_p = 4,
    parameter int lg_p  = lg_width(num_p)
) (
    input  logic [num_p-1:0] eligible_i,
    input  logic [lg_p-1:0]  ptr_i,
    output logic [lg_p-1:0]  pick_o,
    output logic             any_o
);

    logic [2*num_p-1:0] doubled;
    int                 base;
    logic               found;

    assign doubled = {eligible_i, eligible_i};
    assign base    = int'(ptr_i);
    assign any_o   = |eligible_i;

    // The window [base, base+num_p) of the doubled vector is the rotated scan order.
    always_comb begin
        found  = 1'b0;
        pick_o = '0;
        for (int j = 0; j < 2*num_p; j++) begin
            if (!found && (j >= base) && (j < base + num_p) && doubled[j]) begin
                found  = 1'b1;
                pick_o = (j >= num_p) ? lg_p'(j - num_p) : lg_p'(j);
            end
        end
    end

endmodule

// File: rtl/bsg_credit_dispatch_1_to_n.sv
// Credit-based round-robin dispatcher: one valid/ready stream fanned out to num_out_p
// credited consumers, skipping outputs that are disabled or out of credit.
module bsg_credit_dispatch_1_to_n
    import bsg_credit_dispatch_pkg::*;
#(
    parameter  int num_out_p      = 32,
    parameter  int credit_width_p = 4,
    parameter  int init_credits_p = 8,
    localparam int lg_num_out_lp  = lg_width(num_out_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [num_out_p-1:0]     valid_o,
    output logic [lg_num_out_lp-1:0] sel_id_o,
    input  logic [num_out_p-1:0]     out_en_i,
    input  logic [num_out_p-1:0]     credit_return_i,
    output logic                     credit_overflow_o
);

    localparam credit_word_t                max_word_lp    = max_credit(credit_width_p);
    localparam logic [credit_width_p-1:0]   max_credits_lp = max_word_lp[credit_width_p-1:0];
    localparam logic [credit_width_p-1:0]   init_lp        = credit_width_p'(init_credits_p);
    localparam logic [num_out_p-1:0]        one_lp         = num_out_p'(1);
    localparam logic [lg_num_out_lp-1:0]    last_lp        = lg_num_out_lp'(num_out_p - 1);

    if (credit_word_t'(init_credits_p) > max_word_lp) begin : g_bad_init
        $error("init_credits_p does not fit in a credit_width_p counter");
    end

    logic [num_out_p-1:0][credit_width_p-1:0] credits_q, credits_d;
    logic [lg_num_out_lp-1:0]                 ptr_q, ptr_d;
    logic                                     overflow_q, overflow_d;

    logic [num_out_p-1:0]     eligible;
    logic [lg_num_out_lp-1:0] pick;
    logic                     any_eligible;
    logic                     dispatch;

    always_comb begin
        for (int i = 0; i < num_out_p; i++) begin
            eligible[i] = out_en_i[i] & (credits_q[i] != '0);
        end
    end

    bsg_credit_dispatch_rr_pick #(
        .num_p (num_out_p),
        .lg_p  (lg_num_out_lp)
    ) rr_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .pick_o     (pick),
        .any_o      (any_eligible)
    );

    // ready_o is kept free of valid_i so upstream can use it without a loop.
    assign ready_o           = ~reset_i & any_eligible;
    assign sel_id_o          = ready_o ? pick : '0;
    assign dispatch          = valid_i & ready_o;
    assign valid_o           = dispatch ? (one_lp << pick) : '0;
    assign credit_overflow_o = overflow_q;

    // A dispatch and a return on the same output cancel; a lone return saturates.
    always_comb begin
        credits_d  = credits_q;
        overflow_d = overflow_q;
        for (int i = 0; i < num_out_p; i++) begin
            if (credit_return_i[i] && !valid_o[i]) begin
                if (credits_q[i] == max_credits_lp) begin
                    overflow_d = 1'b1;
                end else begin
                    credits_d[i] = credits_q[i] + credit_width_p'(1);
                end
            end else if (valid_o[i] && !credit_return_i[i]) begin
                credits_d[i] = credits_q[i] - credit_width_p'(1);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (dispatch) begin
            ptr_d = (pick == last_lp) ? '0 : pick + lg_num_out_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credits_q  <= {num_out_p{init_lp}};
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_bsg_credit_dispatch_1_to_n.sv
// Directed self-checking bench for bsg_credit_dispatch_1_to_n with 4 outputs,
// 2-bit counters and 2 initial credits per output.
module tb_bsg_credit_dispatch_1_to_n;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic       ready_o;
    logic [3:0] valid_o;
    logic [1:0] sel_id_o;
    logic [3:0] out_en_i;
    logic [3:0] credit_return_i;
    logic       credit_overflow_o;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk_i = ~clk_i;

    bsg_credit_dispatch_1_to_n #(
        .num_out_p      (4),
        .credit_width_p (2),
        .init_credits_p (2)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .valid_o           (valid_o),
        .sel_id_o          (sel_id_o),
        .out_en_i          (out_en_i),
        .credit_return_i   (credit_return_i),
        .credit_overflow_o (credit_overflow_o)
    );

    task automatic applyStimulus(input logic rst, input logic v,
                                 input logic [3:0] en, input logic [3:0] ret);
        reset_i         = rst;
        valid_i         = v;
        out_en_i        = en;
        credit_return_i = ret;
        #2;
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic expReady,
                               input logic [3:0] expValid, input logic [1:0] expSel,
                               input logic expOvf);
        testsRun++;
        assert (ready_o === expReady) else begin
            testsFailed++;
            $error("FAIL %s ready_o observed=%0b expected=%0b", tag, ready_o, expReady);
        end
        testsRun++;
        assert (valid_o === expValid) else begin
            testsFailed++;
            $error("FAIL %s valid_o observed=%b expected=%b", tag, valid_o, expValid);
        end
        testsRun++;
        assert (sel_id_o === expSel) else begin
            testsFailed++;
            $error("FAIL %s sel_id_o observed=%0d expected=%0d", tag, sel_id_o, expSel);
        end
        testsRun++;
        assert (credit_overflow_o === expOvf) else begin
            testsFailed++;
            $error("FAIL %s credit_overflow_o observed=%0b expected=%0b", tag, credit_overflow_o, expOvf);
        end
    endtask

    initial begin
        // Reset: outputs stay quiet even with valid and returns asserted.
        applyStimulus(1'b1, 1'b0, 4'b1111, 4'b0000); cycle();
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111);
        checkOutput("reset_hold", 1'b0, 4'b0000, 2'd0, 1'b0); cycle();
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        checkOutput("post_reset_idle", 1'b1, 4'b0000, 2'd0, 1'b0);

        // Plain rotation through all credits, then nothing left.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
            checkOutput("rr_all", 1'b1, 4'(1 << (i % 4)), 2'(i % 4), 1'b0); cycle();
        end
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        checkOutput("all_empty", 1'b0, 4'b0000, 2'd0, 1'b0); cycle();

        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
        checkOutput("refill1", 1'b0, 4'b0000, 2'd0, 1'b0); cycle();
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
        checkOutput("refill2", 1'b1, 4'b0000, 2'd0, 1'b0); cycle();

        // Output 2 masked off: order 0,1,3 and the pointer wraps to 0.
        applyStimulus(1'b0, 1'b1, 4'b1011, 4'b0000);
        checkOutput("skip_a", 1'b1, 4'b0001, 2'd0, 1'b0); cycle();
        checkOutput("skip_b", 1'b1, 4'b0010, 2'd1, 1'b0); cycle();
        checkOutput("skip_c", 1'b1, 4'b1000, 2'd3, 1'b0); cycle();
        applyStimulus(1'b0, 1'b0, 4'b1011, 4'b0000);
        checkOutput("skip_wrap", 1'b1, 4'b0000, 2'd0, 1'b0);

        // Empty output 1 while the pointer lands on it, then return a credit.
        applyStimulus(1'b0, 1'b1, 4'b0010, 4'b0000);
        checkOutput("drain1", 1'b1, 4'b0010, 2'd1, 1'b0); cycle();
        applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0000);
        checkOutput("ptr_to1", 1'b1, 4'b0001, 2'd0, 1'b0); cycle();
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        checkOutput("skip_empty1", 1'b1, 4'b0100, 2'd2, 1'b0); cycle();
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0010);
        checkOutput("return1", 1'b1, 4'b0000, 2'd3, 1'b0); cycle();
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        checkOutput("resume3", 1'b1, 4'b1000, 2'd3, 1'b0); cycle();
        checkOutput("resume1", 1'b1, 4'b0010, 2'd1, 1'b0); cycle();

        // Output 0: refill to 2, cancel dispatch against return, then saturate.
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0001);
        checkOutput("ret0_a", 1'b1, 4'b0000, 2'd2, 1'b0); cycle();
        checkOutput("ret0_b", 1'b1, 4'b0000, 2'd2, 1'b0); cycle();
        applyStimulus(1'b0, 1'b1, 4'b0001, 4'b0001);
        checkOutput("same_cycle", 1'b1, 4'b0001, 2'd0, 1'b0); cycle();
        applyStimulus(1'b0, 1'b0, 4'b0001, 4'b0001);
        checkOutput("ret0_to3", 1'b1, 4'b0000, 2'd0, 1'b0); cycle();
        checkOutput("ret0_sat", 1'b1, 4'b0000, 2'd0, 1'b0); cycle();

        // Idle cycles: pointer holds, ready stays up, overflow sticks.
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            checkOutput("idle", 1'b1, 4'b0000, 2'd2, 1'b1); cycle();
        end
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        checkOutput("after_idle", 1'b1, 4'b0100, 2'd2, 1'b1); cycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("drain0", 1'b1, 4'b0001, 2'd0, 1'b1); cycle();
        end
        checkOutput("drained", 1'b0, 4'b0000, 2'd0, 1'b1); cycle();

        // Reset mid-stream with the pointer at 2 and partially used credits.
        applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
        checkOutput("refill_pre", 1'b0, 4'b0000, 2'd0, 1'b1); cycle();
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        checkOutput("pre_reset", 1'b1, 4'b0010, 2'd1, 1'b1); cycle();
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111);
        checkOutput("mid_reset", 1'b0, 4'b0000, 2'd0, 1'b1); cycle();
        applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            checkOutput("post_reset_rr", 1'b1, 4'(1 << (i % 4)), 2'(i % 4), 1'b0); cycle();
        end
        checkOutput("post_reset_empty", 1'b0, 4'b0000, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
